// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// controller state encodings and address-field width helpers.
package data_cache_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_REFILL = 2'd2;
  localparam logic [1:0] ST_ACK    = 2'd3;

  function automatic int offset_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_width, input int num_lines, input int line_words);
    return addr_width - 2 - offset_w(line_words) - index_w(num_lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the data cache: one combinational read port,
// one word-write port, a tag/valid set port and an invalidate-all input.
module dcache_array
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              inval_all,
  input  logic [index_w(NUM_LINES)-1:0]     rd_idx,
  input  logic [offset_w(LINE_WORDS)-1:0]   rd_word,
  output logic                              rd_valid,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [DATA_WIDTH-1:0]             rd_data,
  input  logic                              wr_en,
  input  logic [index_w(NUM_LINES)-1:0]     wr_idx,
  input  logic [offset_w(LINE_WORDS)-1:0]   wr_word,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              set_en,
  input  logic [index_w(NUM_LINES)-1:0]     set_idx,
  input  logic [TAG_W-1:0]                  set_tag
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];

  // Valid bits: cleared by reset or invalidate-all, set when a refill completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (inval_all) begin
      valid_q <= '0;
    end else if (set_en) begin
      valid_q[set_idx] <= 1'b1;
    end
  end

  // Tag storage, written together with the valid bit at refill completion.
  always_ff @(posedge clk) begin
    if (set_en) begin
      tag_mem[set_idx] <= set_tag;
    end
  end

  // Data storage, one word per cycle from refill responses or store hits.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_idx, wr_word}] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_word}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache. Load hits return
// combinationally; misses refill a whole line with sequential word reads, and
// stores are forwarded to memory while updating the line only on a hit.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  inval,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W = offset_w(LINE_WORDS);
  localparam int IDX_W = index_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_WIDTH, NUM_LINES, LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  logic [1:0]       state_q;
  logic             inval_pending_q;
  logic [CNT_W-1:0] req_cnt_q;
  logic [CNT_W-1:0] rsp_cnt_q;
  logic [IDX_W-1:0] refill_idx_q;
  logic [TAG_W-1:0] refill_tag_q;

  logic [OFF_W-1:0]      req_word;
  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic                  arr_valid;
  logic [TAG_W-1:0]      arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  hit;
  logic                  do_inval;
  logic                  mem_accept;
  logic                  rsp_last;
  logic                  wr_en;
  logic [IDX_W-1:0]      wr_idx;
  logic [OFF_W-1:0]      wr_word;
  logic [DATA_WIDTH-1:0] wr_data;

  assign req_word   = req_addr[2 +: OFF_W];
  assign req_idx    = req_addr[2 + OFF_W +: IDX_W];
  assign req_tag    = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign hit        = arr_valid && (arr_tag == req_tag);
  assign do_inval   = (state_q == ST_IDLE) && (inval || inval_pending_q);
  assign mem_accept = mem_req_valid && mem_req_ready;
  assign rsp_last   = (state_q == ST_REFILL) && mem_rsp_valid && (rsp_cnt_q == LAST_CNT);

  dcache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .inval_all (do_inval),
    .rd_idx    (req_idx),
    .rd_word   (req_word),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .set_en    (rsp_last),
    .set_idx   (refill_idx_q),
    .set_tag   (refill_tag_q)
  );

  // Core-facing response: hit data with no added latency, stall otherwise.
  always_comb begin
    stall = 1'b0;
    rdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (do_inval || req_write || !hit) begin
            stall = 1'b1;
          end else begin
            rdata = arr_data;
          end
        end
      end
      ST_WRITE, ST_REFILL: stall = req_valid;
      ST_ACK: begin
        if (req_valid && !req_write) begin
          rdata = arr_data;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  // Array word-write select: refill responses fill the latched line, store hits patch one word.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = req_idx;
    wr_word = req_word;
    wr_data = mem_wdata;
    if (state_q == ST_REFILL && mem_rsp_valid) begin
      wr_en   = 1'b1;
      wr_idx  = refill_idx_q;
      wr_word = rsp_cnt_q[OFF_W-1:0];
      wr_data = mem_rdata;
    end else if (state_q == ST_WRITE && mem_accept && hit) begin
      wr_en = 1'b1;
    end
  end

  // Line being refilled; captured when the miss is detected so the fill is independent of the core bus.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && req_valid && !req_write && !do_inval && !hit) begin
      refill_idx_q <= req_idx;
      refill_tag_q <= req_tag;
    end
  end

  // Controller: issues memory requests, tracks refill progress and deferred invalidation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      inval_pending_q <= 1'b0;
      req_cnt_q       <= '0;
      rsp_cnt_q       <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_write   <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      if (inval && state_q != ST_IDLE) begin
        inval_pending_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (do_inval) begin
            inval_pending_q <= 1'b0;
          end else if (req_valid && req_write) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b1;
            mem_addr      <= req_addr & ~ADDR_WIDTH'(3);
            mem_wdata     <= req_wdata;
            state_q       <= ST_WRITE;
          end else if (req_valid && !hit) begin
            mem_req_valid <= 1'b1;
            mem_req_write <= 1'b0;
            mem_addr      <= req_addr & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
            state_q       <= ST_REFILL;
          end
        end
        ST_WRITE: begin
          if (mem_accept) begin
            mem_req_valid <= 1'b0;
            state_q       <= ST_ACK;
          end
        end
        ST_REFILL: begin
          if (mem_accept) begin
            req_cnt_q <= req_cnt_q + CNT_W'(1);
            if (req_cnt_q == LAST_CNT) begin
              mem_req_valid <= 1'b0;
            end else begin
              mem_addr <= mem_addr + ADDR_WIDTH'(4);
            end
          end
          if (mem_rsp_valid) begin
            if (rsp_cnt_q == LAST_CNT) begin
              rsp_cnt_q <= '0;
              req_cnt_q <= '0;
              state_q   <= ST_ACK;
            end else begin
              rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_ACK: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: stimulus pushes expected core responses and
// expected memory requests; one negedge process models the memory and checks.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        inval;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    int          lat;
  } core_exp_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  core_exp_t   core_q[$];
  mem_exp_t    mem_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] mem_words [1024];

  int checks       = 0;
  int errors       = 0;
  int lat_cnt      = 0;
  int done_cnt     = 0;
  int ready_wait   = 0;
  int wait_cnt     = 0;
  int rsp_budget   = -1;
  int stray_pulses = 0;
  logic        holding = 1'b0;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  data_cache dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .inval         (inval),
    .rdata         (rdata),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_write (mem_req_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic exp_refill(input logic [31:0] base);
    mem_exp_t m;
    for (int i = 0; i < 4; i++) begin
      m.wr = 1'b0;
      m.addr = base + 32'(4 * i);
      m.wdata = '0;
      mem_q.push_back(m);
    end
  endtask

  task automatic exp_write(input logic [31:0] addr, input logic [31:0] data);
    mem_exp_t m;
    m.wr = 1'b1;
    m.addr = addr;
    m.wdata = data;
    mem_q.push_back(m);
  endtask

  task automatic core_access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input int exp_lat);
    core_exp_t e;
    int start;
    bit ok;
    e.wr = wr;
    e.rdata = exp_rd;
    e.lat = exp_lat;
    core_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk);
      if (done_cnt != start) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL completion addr %h: actual none required response", addr);
      if (core_q.size() > 0) void'(core_q.pop_front());
    end
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Negedge process: core-side scoreboard monitor plus memory model.
  task automatic run_monitor();
    core_exp_t e;
    mem_exp_t  m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        lat_cnt = 0;
        rsp_q.delete();
        wait_cnt = 0;
        holding = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (req_valid) begin
          if (stall) begin
            lat_cnt++;
          end else begin
            if (core_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL core completion: actual unexpected required none");
            end else begin
              e = core_q.pop_front();
              if (!e.wr) chk("load rdata", rdata, e.rdata);
              chk("stall cycles", 32'(lat_cnt), 32'(e.lat));
            end
            lat_cnt = 0;
            done_cnt++;
          end
        end else begin
          lat_cnt = 0;
        end
        if (stray_pulses > 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = 32'hBAD0_0000 + 32'(stray_pulses);
          stray_pulses--;
        end else if (rsp_q.size() > 0 && rsp_budget != 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = rsp_q.pop_front();
          if (rsp_budget > 0) rsp_budget--;
        end else begin
          mem_rsp_valid = 1'b0;
          mem_rdata = '0;
        end
        if (mem_req_valid) begin
          if (holding) begin
            chk("held mem_addr", mem_addr, hold_addr);
            chk("held mem_wdata", mem_wdata, hold_wdata);
          end
          if (wait_cnt < ready_wait) begin
            mem_req_ready = 1'b0;
            wait_cnt++;
            holding = 1'b1;
            hold_addr = mem_addr;
            hold_wdata = mem_wdata;
          end else begin
            mem_req_ready = 1'b1;
            wait_cnt = 0;
            holding = 1'b0;
            if (mem_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mem request: actual addr %h required none", mem_addr);
            end else begin
              m = mem_q.pop_front();
              chk("mem_req_write", 32'(mem_req_write), 32'(m.wr));
              chk("mem_addr", mem_addr, m.addr);
              if (m.wr) chk("mem_wdata", mem_wdata, m.wdata);
            end
            if (mem_req_write) mem_words[mem_addr[11:2]] = mem_wdata;
            else rsp_q.push_back(mem_words[mem_addr[11:2]]);
          end
        end else begin
          mem_req_ready = (ready_wait == 0);
          holding = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    inval = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) mem_words[i] = 32'h1000_0000 + 32'(i);
    mem_words[32'h40] = 32'hA0;
    mem_words[32'h41] = 32'hA1;
    mem_words[32'h42] = 32'hA2;
    mem_words[32'h43] = 32'hA3;
    fork
      run_monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("reset mem_req_write", 32'(mem_req_write), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // cold miss then hit in the same line
    exp_refill(32'h100);
    core_access(1'b0, 32'h100, '0, 32'hA0, 6);
    core_access(1'b0, 32'h108, '0, 32'hA2, 0);

    // store hit with delayed ready, then reload hits the new value
    ready_wait = 3;
    exp_write(32'h104, 32'hDEAD);
    core_access(1'b1, 32'h104, 32'hDEAD, '0, 5);
    ready_wait = 0;
    core_access(1'b0, 32'h104, '0, 32'hDEAD, 0);

    // store miss does not allocate
    exp_write(32'h400, 32'h1234_5678);
    core_access(1'b1, 32'h400, 32'h1234_5678, '0, 2);
    exp_refill(32'h400);
    core_access(1'b0, 32'h400, '0, 32'h1234_5678, 6);

    // aliasing lines on the same index
    exp_refill(32'h100);
    core_access(1'b0, 32'h100, '0, 32'hA0, 6);
    core_access(1'b0, 32'h104, '0, 32'hDEAD, 0);
    exp_refill(32'h500);
    core_access(1'b0, 32'h500, '0, 32'h1000_0140, 6);
    exp_refill(32'h100);
    core_access(1'b0, 32'h100, '0, 32'hA0, 6);
    core_access(1'b0, 32'h10C, '0, 32'hA3, 0);

    // invalidate during refill is deferred to the next idle cycle
    exp_refill(32'h200);
    fork
      core_access(1'b0, 32'h200, '0, 32'h1000_0080, 6);
      begin
        repeat (3) @(posedge clk);
        #1 inval = 1'b1;
        @(posedge clk);
        #1 inval = 1'b0;
      end
    join
    exp_refill(32'h200);
    core_access(1'b0, 32'h200, '0, 32'h1000_0080, 6);

    // invalidate in idle together with a would-be hit
    exp_refill(32'h200);
    fork
      core_access(1'b0, 32'h204, '0, 32'h1000_0081, 7);
      begin
        @(posedge clk);
        #1 inval = 1'b1;
        @(posedge clk);
        #1 inval = 1'b0;
      end
    join

    // reset in the middle of a refill, then stray responses
    exp_refill(32'h300);
    rsp_budget = 2;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 32'h300;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("mid-reset stall", 32'(stall), 32'd0);
    chk("mid-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rsp_budget = -1;
    stray_pulses = 2;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    chk("post-reset stall", 32'(stall), 32'd0);
    chk("post-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    exp_refill(32'h300);
    core_access(1'b0, 32'h300, '0, 32'h1000_00C0, 6);

    repeat (4) @(posedge clk);
    chk("core queue drained", 32'(core_q.size()), 32'd0);
    chk("mem queue drained", 32'(mem_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
